// File: rtl/instr_encode.sv
// RV32I field-to-instruction encoder feeding a DEPTH-entry valid/ready FIFO.
// Optional immediate range checking is enabled by defining ENC_IMM_CHECK_EN.
module instr_encode #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [6:0]    in_opcode,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [2:0]    in_funct3,
  input  logic [6:0]    in_funct7,
  input  logic [31:0]   in_imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic          out_illegal,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

`ifdef ENC_IMM_CHECK_EN
  function automatic logic fits_s12(input logic [31:0] imm);
    return (imm[31:11] == {21{imm[11]}});
  endfunction

  function automatic logic fits_s13(input logic [31:0] imm);
    return (imm[31:12] == {20{imm[12]}});
  endfunction

  function automatic logic imm_range_bad(input logic [6:0] opc, input logic [31:0] imm);
    logic bad;
    case (opc)
      OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_STORE: bad = !fits_s12(imm);
      OPC_BRANCH:                               bad = !fits_s13(imm) || imm[0];
      OPC_LUI:                                  bad = (imm[11:0] != 12'h000);
      default:                                  bad = 1'b0;
    endcase
    return bad;
  endfunction
`endif

  logic [31:0] raw_word_s;
  logic        raw_ill_s;
  logic        imm_bad_s;
  logic [31:0] enc_word_s;
  logic        enc_ill_s;

  logic [32:0]   mem_q [DEPTH];
  logic [32:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_s;
  logic          pop_s;

  // Pack the field bundle according to the major opcode.
  always_comb begin
    raw_word_s = NOP_WORD;
    raw_ill_s  = 1'b1;
    case (in_opcode)
      OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
        raw_word_s = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        raw_ill_s  = 1'b0;
      end
      OPC_LUI: begin
        raw_word_s = {in_imm[31:12], in_rd, in_opcode};
        raw_ill_s  = 1'b0;
      end
      OPC_OP: begin
        raw_word_s = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        raw_ill_s  = 1'b0;
      end
      OPC_STORE: begin
        raw_word_s = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        raw_ill_s  = 1'b0;
      end
      OPC_BRANCH: begin
        raw_word_s = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:1], in_imm[11], in_opcode};
        raw_ill_s  = 1'b0;
      end
      default: begin
        raw_word_s = NOP_WORD;
        raw_ill_s  = 1'b1;
      end
    endcase
  end

`ifdef ENC_IMM_CHECK_EN
  assign imm_bad_s = imm_range_bad(in_opcode, in_imm);
`else
  assign imm_bad_s = 1'b0;
`endif

  assign enc_word_s = imm_bad_s ? NOP_WORD : raw_word_s;
  assign enc_ill_s  = raw_ill_s | imm_bad_s;

  // A push is refused at full even when a pop happens in the same cycle.
  assign push_s = in_valid && (count_q != CW'(DEPTH));
  assign pop_s  = out_ready && (count_q != {CW{1'b0}});

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = {enc_ill_s, enc_word_s};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; storage is cleared so the idle head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 33'd0;
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign in_ready    = (count_q != CW'(DEPTH));
  assign out_valid   = (count_q != {CW{1'b0}});
  assign out_instr   = mem_q[rd_ptr_q][31:0];
  assign out_illegal = mem_q[rd_ptr_q][32];
  assign count       = count_q;

endmodule
